// File: rtl/video_timing_gen.sv
// Programmable raster timing generator with frame-aligned mode switching.
// New modes are checked one cycle after capture and swapped in at frame wrap.
module video_timing_gen #(
  parameter int   CW       = 12,
  parameter int   DEF_HA   = 640,
  parameter int   DEF_HF   = 16,
  parameter int   DEF_HS   = 96,
  parameter int   DEF_HB   = 48,
  parameter int   DEF_VA   = 480,
  parameter int   DEF_VF   = 10,
  parameter int   DEF_VS   = 2,
  parameter int   DEF_VB   = 33,
  parameter logic DEF_HPOL = 1'b0,
  parameter logic DEF_VPOL = 1'b0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          mode_valid,
  output logic          mode_ready,
  input  logic [CW-1:0] mode_h_act,
  input  logic [CW-1:0] mode_h_fp,
  input  logic [CW-1:0] mode_h_sync,
  input  logic [CW-1:0] mode_h_bp,
  input  logic [CW-1:0] mode_v_act,
  input  logic [CW-1:0] mode_v_fp,
  input  logic [CW-1:0] mode_v_sync,
  input  logic [CW-1:0] mode_v_bp,
  input  logic          mode_h_pol,
  input  logic          mode_v_pol,
  output logic [CW-1:0] counter_x,
  output logic [CW-1:0] counter_y,
  output logic [CW-1:0] vis_x,
  output logic [CW-1:0] vis_y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic          mode_err
);

  localparam int TW = CW + 2;
  localparam logic [TW-1:0] LIM = TW'(1) << CW;

  typedef struct packed {
    logic [CW-1:0] ha;
    logic [CW-1:0] hf;
    logic [CW-1:0] hs;
    logic [CW-1:0] hb;
    logic [CW-1:0] va;
    logic [CW-1:0] vf;
    logic [CW-1:0] vs;
    logic [CW-1:0] vb;
    logic          hp;
    logic          vp;
  } mode_t;

  localparam mode_t DEF = '{
    ha: CW'(DEF_HA), hf: CW'(DEF_HF),
    hs: CW'(DEF_HS), hb: CW'(DEF_HB),
    va: CW'(DEF_VA), vf: CW'(DEF_VF),
    vs: CW'(DEF_VS), vb: CW'(DEF_VB),
    hp: DEF_HPOL, vp: DEF_VPOL
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHK,
    S_WAIT
  } st_t;

  st_t   r_st, w_st_nx;
  mode_t r_cur, r_pm, w_in;

  logic [CW-1:0] r_x, r_y;
  logic [TW-1:0] w_htot, w_vtot;
  logic [TW-1:0] w_ph, w_pv;
  logic [TW-1:0] w_hb0, w_hb1;
  logic [TW-1:0] w_vb0, w_vb1;
  logic [TW-1:0] w_xe, w_ye;
  logic          w_xend, w_yend, w_wrap;
  logic          w_legal, w_acc;
  logic          w_apply, w_err;

  assign w_in = '{
    ha: mode_h_act, hf: mode_h_fp,
    hs: mode_h_sync, hb: mode_h_bp,
    va: mode_v_act, vf: mode_v_fp,
    vs: mode_v_sync, vb: mode_v_bp,
    hp: mode_h_pol, vp: mode_v_pol
  };

  assign w_hb0  = TW'(r_cur.hs) + TW'(r_cur.hb);
  assign w_hb1  = w_hb0 + TW'(r_cur.ha);
  assign w_htot = w_hb1 + TW'(r_cur.hf);
  assign w_vb0  = TW'(r_cur.vs) + TW'(r_cur.vb);
  assign w_vb1  = w_vb0 + TW'(r_cur.va);
  assign w_vtot = w_vb1 + TW'(r_cur.vf);

  assign w_ph = TW'(r_pm.hs) + TW'(r_pm.hb)
              + TW'(r_pm.ha) + TW'(r_pm.hf);
  assign w_pv = TW'(r_pm.vs) + TW'(r_pm.vb)
              + TW'(r_pm.va) + TW'(r_pm.vf);

  assign w_legal = (|r_pm.hs) & (|r_pm.ha)
                 & (|r_pm.vs) & (|r_pm.va)
                 & (w_ph <= LIM) & (w_pv <= LIM);

  assign w_xe   = TW'(r_x);
  assign w_ye   = TW'(r_y);
  assign w_xend = (w_xe == w_htot - TW'(1));
  assign w_yend = (w_ye == w_vtot - TW'(1));
  assign w_wrap = w_xend & w_yend;

  assign mode_ready = (r_st == S_IDLE);
  assign w_acc      = mode_valid & mode_ready;
  assign counter_x  = r_x;
  assign counter_y  = r_y;

  always_ff @(posedge clock) begin
    if (!reset_n) r_st <= S_IDLE;
    else          r_st <= w_st_nx;
  end

  always_comb begin
    w_st_nx = r_st;
    w_apply = 1'b0;
    w_err   = 1'b0;
    unique case (r_st)
      S_IDLE: if (mode_valid) w_st_nx = S_CHK;
      S_CHK: begin
        if (!w_legal) begin
          w_err   = 1'b1;
          w_st_nx = S_IDLE;
        end else if (w_wrap) begin
          w_apply = 1'b1;
          w_st_nx = S_IDLE;
        end else begin
          w_st_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_wrap) begin
          w_apply = 1'b1;
          w_st_nx = S_IDLE;
        end
      end
      default: w_st_nx = S_IDLE;
    endcase
  end

  // Apply and counter restart share one edge, so x never outruns a smaller total.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_cur       <= DEF;
      r_pm        <= '0;
      vis_x       <= '0;
      vis_y       <= '0;
      de          <= 1'b0;
      hsync       <= ~DEF_HPOL;
      vsync       <= ~DEF_VPOL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      mode_err    <= 1'b0;
    end else begin
      if (w_acc) r_pm <= w_in;
      if (w_apply) begin
        r_cur <= r_pm;
        r_x   <= '0;
        r_y   <= '0;
      end else if (w_xend) begin
        r_x <= '0;
        r_y <= w_yend ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
      hsync <= (r_x < r_cur.hs) ? r_cur.hp : ~r_cur.hp;
      vsync <= (r_y < r_cur.vs) ? r_cur.vp : ~r_cur.vp;
      de    <= (w_xe >= w_hb0) & (w_xe < w_hb1)
             & (w_ye >= w_vb0) & (w_ye < w_vb1);
      vis_x       <= r_x - r_cur.hs - r_cur.hb;
      vis_y       <= r_y - r_cur.vs - r_cur.vb;
      line_start  <= (r_x == '0);
      frame_start <= (r_x == '0) & (r_y == '0);
      mode_err    <= w_err;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised bench for video_timing_gen against a cycle-count raster model.
// Small reset defaults keep whole frames short enough to simulate.
module tb_video_timing_gen;

  localparam int CW = 12;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    bit hp, vp;
  } md_t;

  localparam md_t DEF = '{
    ha: 16, hf: 2, hs: 4, hb: 3,
    va: 8, vf: 1, vs: 2, vb: 2,
    hp: 1'b0, vp: 1'b1
  };

  logic          clock = 1'b0;
  logic          reset_n;
  logic          mode_valid;
  logic          mode_ready;
  logic [CW-1:0] mode_h_act, mode_h_fp;
  logic [CW-1:0] mode_h_sync, mode_h_bp;
  logic [CW-1:0] mode_v_act, mode_v_fp;
  logic [CW-1:0] mode_v_sync, mode_v_bp;
  logic          mode_h_pol, mode_v_pol;
  logic [CW-1:0] counter_x, counter_y;
  logic [CW-1:0] vis_x, vis_y;
  logic          hsync, vsync, de;
  logic          line_start, frame_start;
  logic          mode_err;

  video_timing_gen #(
    .CW(CW),
    .DEF_HA(16), .DEF_HF(2),
    .DEF_HS(4), .DEF_HB(3),
    .DEF_VA(8), .DEF_VF(1),
    .DEF_VS(2), .DEF_VB(2),
    .DEF_HPOL(1'b0), .DEF_VPOL(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .mode_valid(mode_valid),
    .mode_ready(mode_ready),
    .mode_h_act(mode_h_act),
    .mode_h_fp(mode_h_fp),
    .mode_h_sync(mode_h_sync),
    .mode_h_bp(mode_h_bp),
    .mode_v_act(mode_v_act),
    .mode_v_fp(mode_v_fp),
    .mode_v_sync(mode_v_sync),
    .mode_v_bp(mode_v_bp),
    .mode_h_pol(mode_h_pol),
    .mode_v_pol(mode_v_pol),
    .counter_x(counter_x),
    .counter_y(counter_y),
    .vis_x(vis_x), .vis_y(vis_y),
    .hsync(hsync), .vsync(vsync),
    .de(de),
    .line_start(line_start),
    .frame_start(frame_start),
    .mode_err(mode_err)
  );

  always #5 clock = ~clock;

  int nchk = 0;
  int nerr = 0;

  md_t m = DEF;
  md_t pm;
  int  cyc = 0;
  bit  mpend = 0;
  bit  mchk = 0;

  int e_x, e_y, e_vx, e_vy;
  bit e_hs, e_vs, e_de;
  bit e_ls, e_fs, e_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int htot(md_t v);
    return v.hs + v.hb + v.ha + v.hf;
  endfunction

  function automatic int vtot(md_t v);
    return v.vs + v.vb + v.va + v.vf;
  endfunction

  function automatic bit legal(md_t v);
    return v.hs != 0 && v.ha != 0 &&
           v.vs != 0 && v.va != 0 &&
           htot(v) <= (1 << CW) &&
           vtot(v) <= (1 << CW);
  endfunction

  function automatic md_t rnd_mode(bit bad);
    md_t v;
    v.ha = $urandom_range(1, 20);
    v.hf = $urandom_range(0, 4);
    v.hs = $urandom_range(1, 5);
    v.hb = $urandom_range(0, 4);
    v.va = $urandom_range(1, 10);
    v.vf = $urandom_range(0, 2);
    v.vs = $urandom_range(1, 3);
    v.vb = $urandom_range(0, 2);
    v.hp = 1'($urandom_range(0, 1));
    v.vp = 1'($urandom_range(0, 1));
    if (bad && $urandom_range(0, 2) == 0) begin
      case ($urandom_range(0, 3))
        0: v.hs = 0;
        1: v.ha = 0;
        2: v.vs = 0;
        default: v.va = 0;
      endcase
    end
    return v;
  endfunction

  task automatic drive(input md_t v);
    mode_h_act  = CW'(v.ha);
    mode_h_fp   = CW'(v.hf);
    mode_h_sync = CW'(v.hs);
    mode_h_bp   = CW'(v.hb);
    mode_v_act  = CW'(v.va);
    mode_v_fp   = CW'(v.vf);
    mode_v_sync = CW'(v.vs);
    mode_v_bp   = CW'(v.vb);
    mode_h_pol  = v.hp;
    mode_v_pol  = v.vp;
  endtask

  function automatic md_t inputs();
    md_t v;
    v.ha = int'(mode_h_act);
    v.hf = int'(mode_h_fp);
    v.hs = int'(mode_h_sync);
    v.hb = int'(mode_h_bp);
    v.va = int'(mode_v_act);
    v.vf = int'(mode_v_fp);
    v.vs = int'(mode_v_sync);
    v.vb = int'(mode_v_bp);
    v.hp = mode_h_pol;
    v.vp = mode_v_pol;
    return v;
  endfunction

  // Raster position is cycles since frame start; outputs lag it by one clock.
  task automatic step();
    int ht, vt, x, y;
    bit acc, errn, wrap, apl;
    md_t inm;
    ht   = htot(m);
    vt   = vtot(m);
    x    = cyc % ht;
    y    = cyc / ht;
    inm  = inputs();
    acc  = mode_valid && !mpend;
    errn = mchk && !legal(pm);
    wrap = (cyc == ht * vt - 1);
    apl  = mpend && legal(pm) && wrap;
    @(posedge clock);
    if (!reset_n) begin
      m = DEF; cyc = 0;
      mpend = 0; mchk = 0;
      e_hs = !DEF.hp; e_vs = !DEF.vp;
      e_de = 0; e_vx = 0; e_vy = 0;
      e_ls = 0; e_fs = 0; e_err = 0;
    end else begin
      e_hs = (x < m.hs) ? m.hp : !m.hp;
      e_vs = (y < m.vs) ? m.vp : !m.vp;
      e_de = x >= m.hs + m.hb &&
             x < m.hs + m.hb + m.ha &&
             y >= m.vs + m.vb &&
             y < m.vs + m.vb + m.va;
      e_vx = (x - m.hs - m.hb) & 'hFFF;
      e_vy = (y - m.vs - m.vb) & 'hFFF;
      e_ls = (x == 0);
      e_fs = (x == 0 && y == 0);
      e_err = errn;
      if (apl) begin
        m = pm; cyc = 0; mpend = 0;
      end else begin
        cyc = wrap ? 0 : cyc + 1;
      end
      if (errn) mpend = 0;
      mchk = acc;
      if (acc) begin
        mpend = 1;
        pm = inm;
      end
    end
    @(negedge clock);
    ht  = htot(m);
    e_x = cyc % ht;
    e_y = cyc / ht;
    chk("cnt_x", 32'(counter_x), 32'(e_x));
    chk("cnt_y", 32'(counter_y), 32'(e_y));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("de", 32'(de), 32'(e_de));
    if (e_de) begin
      chk("vis_x", 32'(vis_x), 32'(e_vx));
      chk("vis_y", 32'(vis_y), 32'(e_vy));
    end
    chk("line_start", 32'(line_start), 32'(e_ls));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("mode_err", 32'(mode_err), 32'(e_err));
    chk("mode_ready", 32'(mode_ready), 32'(!mpend));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic offer(input md_t v);
    drive(v);
    mode_valid = 1'b1;
    step();
    mode_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n = 0;
    while (mpend && n < lim) begin
      step();
      n++;
    end
    chk(tag, 32'(mode_ready), 32'd1);
  endtask

  md_t v;

  initial begin
    reset_n = 1'b0;
    mode_valid = 1'b0;
    drive(DEF);
    run(3);
    reset_n = 1'b1;
    run(2 * htot(DEF) * vtot(DEF) + 5);

    // Mid-frame offer, then keep valid high with other fields while pending.
    for (int i = 0; i < 500 && e_y != 5; i++) step();
    v = rnd_mode(0);
    drive(v);
    mode_valid = 1'b1;
    step();
    for (int i = 0; i < 14; i++) begin
      drive(rnd_mode(0));
      step();
    end
    mode_valid = 1'b0;
    wait_idle("apply_mid", 2000);
    run(2 * htot(m) * vtot(m));

    for (int k = 0; k < 8; k++) begin
      run($urandom_range(0, 200));
      offer(rnd_mode(1));
      wait_idle("apply_rnd", 3000);
      run(htot(m) * vtot(m) + 10);
    end

    v = rnd_mode(0);
    v.ha = 0;
    offer(v);
    wait_idle("ill_ha0", 10);
    run(50);

    v.ha = 4000; v.hs = 50; v.hb = 40; v.hf = 7;
    offer(v);
    wait_idle("ill_4097", 10);
    run(50);

    v.hf = 6; v.va = 1; v.vs = 1;
    v.vf = 0; v.vb = 0;
    offer(v);
    wait_idle("max_4096", 1000);
    run(8192 + 10);

    v = '{ha: 1280, hf: 110, hs: 40, hb: 220,
          va: 720, vf: 5, vs: 5, vb: 20,
          hp: 1'b1, vp: 1'b1};
    offer(v);
    wait_idle("apply_720p", 10000);
    run(3400);

    v = rnd_mode(0);
    offer(v);
    run(3);
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    run(htot(DEF) * vtot(DEF) * 2 + 5);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
